// File: rtl/cpu_types_pkg.sv
// Shared CPU types: memory access size and memory-stage sequencing states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        WORD = 2'b00,
        HALF = 2'b01,
        BYTE = 2'b10
    } memsize_t;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } memstate_t;

endpackage

// File: rtl/mem_align.sv
// Big-endian sub-word alignment: load extract/extend and store merge into a read word.
module mem_align
    import cpu_types_pkg::*;
(
    input  memsize_t    size,
    input  logic        zext,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] sdata,
    output logic [31:0] ldata,
    output logic [31:0] mdata
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // Offset 0 is the most significant byte.
        case (offset)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = offset[1] ? rdata[15:0] : rdata[31:16];

        ldata = rdata;
        mdata = sdata;
        case (size)
            BYTE: begin
                ldata = zext ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                mdata = rdata;
                case (offset)
                    2'd0:    mdata[31:24] = sdata[7:0];
                    2'd1:    mdata[23:16] = sdata[7:0];
                    2'd2:    mdata[15:8]  = sdata[7:0];
                    default: mdata[7:0]   = sdata[7:0];
                endcase
            end
            HALF: begin
                ldata = zext ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
                mdata = rdata;
                if (offset[1]) mdata[15:0]  = sdata[15:0];
                else           mdata[31:16] = sdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: dcache request sequencing, load buffering and stall generation.
// Defining SUBWORD_EN adds byte/half loads and read-modify-write byte/half stores.
module mem_stage
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        advance,
    input  logic        op_valid,
    input  logic        memREN,
    input  logic        memWEN,
    input  logic [1:0]  memsize,
    input  logic        memunsigned,
    input  logic [31:0] addr,
    input  logic [31:0] storedata,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic [31:0] loaddata,
    output logic        mem_busy
);
    memstate_t   state, state_next;
    logic [31:0] loadbuf;
    logic [31:0] load_val;
    logic        pending;
    logic        sub_store;
    logic        load_hit;

    assign pending  = op_valid & (memREN | memWEN);
    assign dmemaddr = {addr[31:2], 2'b00};

`ifdef SUBWORD_EN
    memsize_t    size;
    logic [31:0] merge_val;
    logic [31:0] mergebuf;
    logic        merge_hit;

    assign size      = memsize_t'(memsize);
    assign sub_store = ~memREN & memWEN & ((size == HALF) | (size == BYTE));
    // The read half of a sub-word store may complete in the issue cycle or later in RD.
    assign merge_hit = pending & sub_store & dhit & ((state == IDLE) | (state == RD));
    assign dmemstore = (state == WR) ? mergebuf : storedata;

    mem_align u_align (
        .size   (size),
        .zext   (memunsigned),
        .offset (addr[1:0]),
        .rdata  (dmemload),
        .sdata  (storedata),
        .ldata  (load_val),
        .mdata  (merge_val)
    );

    always_ff @(posedge CLK) begin
        if (RST)            mergebuf <= '0;
        else if (merge_hit) mergebuf <= merge_val;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{memsize, memunsigned, addr[1:0]};
    assign sub_store  = 1'b0;
    assign load_val   = dmemload;
    assign dmemstore  = storedata;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            loadbuf <= '0;
        end else begin
            state <= state_next;
            if (load_hit) loadbuf <= load_val;
        end
    end

    always_comb begin
        state_next = state;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        mem_busy   = 1'b0;
        load_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (pending && sub_store) begin
                    dmemREN    = 1'b1;
                    mem_busy   = 1'b1;
                    state_next = dhit ? WR : RD;
                end else if (pending) begin
                    dmemREN  = memREN;
                    dmemWEN  = ~memREN;
                    mem_busy = ~dhit;
                    load_hit = dhit & memREN;
                    if (dhit) state_next = DONE;
                end
            end
            RD: begin
                if (pending) begin
                    dmemREN  = 1'b1;
                    mem_busy = 1'b1;
                    if (dhit) state_next = WR;
                end else begin
                    state_next = IDLE;
                end
            end
            WR: begin
                if (pending) begin
                    dmemWEN  = 1'b1;
                    mem_busy = ~dhit;
                    if (dhit) state_next = DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            DONE: ;
            default: state_next = IDLE;
        endcase
        // A pipeline advance always retires or abandons the current op.
        if (advance) state_next = IDLE;
        if (RST) begin
            dmemREN  = 1'b0;
            dmemWEN  = 1'b0;
            mem_busy = 1'b0;
            load_hit = 1'b0;
        end
    end

    assign loaddata = RST ? '0 : (load_hit ? load_val : loadbuf);

endmodule
